dw_conv_win_ctrl: RTL

- Frame-level sequencer for the depthwise-conv preprocess datapath (row buffer + 3x3 window generator).
- Latches the frame geometry, programs the row-buffer length, and gates the pixel stream into the datapath.
- Tracks row/column position and tags which generated windows are valid conv outputs (stride 1, no padding).
- Flushes the window pipeline and signals frame completion.

---
 rtl/dw_conv_pkg.sv | 18 +
 rtl/dw_win_tag_pipe.sv | 36 +++
 rtl/dw_conv_win_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dw_conv_pkg.sv
// Shared definitions for the depthwise-conv window controller: FSM encodings,
// default frame limits and the legal-geometry check.
package dw_conv_pkg;

  localparam int IMG_W_MAX_DEF = 320;
  localparam int IMG_H_MAX_DEF = 320;
  localparam int KERNEL_SIZE   = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CFG   = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  function automatic logic geom_ok(input int w, input int h, input int w_max, input int h_max);
    return (w >= KERNEL_SIZE) && (h >= KERNEL_SIZE) && (w <= w_max) && (h <= h_max);
  endfunction

endpackage

// File: rtl/dw_win_tag_pipe.sv
// Delay line carrying valid-window / last-window tags alongside the window
// generator so they emerge in step with the datapath output.
module dw_win_tag_pipe #(
  parameter int WIN_LAT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  input  logic i_tag,
  input  logic i_last,
  output logic o_win_valid,
  output logic o_win_last
);

  logic [WIN_LAT-1:0] r_valid;
  logic [WIN_LAT-1:0] r_last;

  // Shift tags every cycle; an idle input cycle injects a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_last  <= '0;
    end else begin
      r_valid[0] <= i_valid & i_tag;
      r_last[0]  <= i_valid & i_tag & i_last;
      for (int i = 1; i < WIN_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  assign o_win_valid = r_valid[WIN_LAT-1];
  assign o_win_last  = r_last[WIN_LAT-1];

endmodule

// File: rtl/dw_conv_win_ctrl.sv
// Frame sequencer for the depthwise-conv row buffer + 3x3 window datapath.
// Defining DW_CONV_WIN_CTRL_STRIDE2_EN adds i_cfg_stride2 (even-anchored windows).
module dw_conv_win_ctrl
  import dw_conv_pkg::*;
#(
  parameter int IMG_W_MAX        = IMG_W_MAX_DEF,
  parameter int IMG_H_MAX        = IMG_H_MAX_DEF,
  parameter int ROW_BUFFER_DEPTH = $clog2(IMG_W_MAX - 2),
  parameter int WIN_LAT          = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cfg_start,
  input  logic [$clog2(IMG_W_MAX+1)-1:0] i_cfg_img_w,
  input  logic [$clog2(IMG_H_MAX+1)-1:0] i_cfg_img_h,
`ifdef DW_CONV_WIN_CTRL_STRIDE2_EN
  input  logic                           i_cfg_stride2,
`endif
  input  logic                           i_s_valid,
  output logic                           o_s_ready,
  output logic                           o_pp_valid_in,
  output logic [ROW_BUFFER_DEPTH-1:0]    o_buff_len_ctrl,
  output logic                           o_buff_len_rst,
  output logic                           o_win_valid,
  output logic                           o_win_last,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_cfg_err
);

  localparam int WW    = $clog2(IMG_W_MAX + 1);
  localparam int HW    = $clog2(IMG_H_MAX + 1);
  localparam int COL_W = $clog2(IMG_W_MAX);
  localparam int ROW_W = $clog2(IMG_H_MAX);
  localparam int FC_W  = (WIN_LAT > 1) ? $clog2(WIN_LAT) : 1;

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_nxt;
  logic [WW-1:0]               r_img_w;
  logic [HW-1:0]               r_img_h;
  logic [COL_W-1:0]            r_col;
  logic [ROW_W-1:0]            r_row;
  logic [COL_W-1:0]            w_col_end;
  logic [ROW_W-1:0]            w_row_end;
  logic [COL_W-1:0]            w_col_anchor;
  logic [ROW_W-1:0]            w_row_anchor;
  logic [FC_W-1:0]             r_flush_cnt;
  logic [FC_W-1:0]             w_flush_nxt;
  logic [ROW_BUFFER_DEPTH-1:0] r_buff_len;
  logic                        r_done;
  logic                        w_done_nxt;
  logic                        r_cfg_err;
  logic                        w_start_acc;
  logic                        w_geom_ok;
  logic                        w_hs;
  logic                        w_at_end;
  logic                        w_tag;
  logic                        w_tag_last;
  logic                        w_stride2;

`ifdef DW_CONV_WIN_CTRL_STRIDE2_EN
  logic r_stride2;

  // Stride mode is captured with the geometry and held for the whole frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stride2 <= 1'b0;
    end else if (w_start_acc) begin
      r_stride2 <= i_cfg_stride2;
    end else begin
      r_stride2 <= r_stride2;
    end
  end

  assign w_stride2 = r_stride2;
`else
  assign w_stride2 = 1'b0;
`endif

  assign w_start_acc = (r_state == ST_IDLE) && i_cfg_start;
  assign w_geom_ok   = geom_ok(int'(r_img_w), int'(r_img_h), IMG_W_MAX, IMG_H_MAX);
  assign w_col_end   = COL_W'(r_img_w - WW'(1));
  assign w_row_end   = ROW_W'(r_img_h - HW'(1));
  assign w_hs        = o_pp_valid_in;
  assign w_at_end    = (r_col == w_col_end) && (r_row == w_row_end);

  // In stride-2 mode the last window sits on the last even row/column.
  assign w_col_anchor = w_stride2 ? (w_col_end & ~COL_W'(1)) : w_col_end;
  assign w_row_anchor = w_stride2 ? (w_row_end & ~ROW_W'(1)) : w_row_end;

  assign w_tag = (r_row >= ROW_W'(KERNEL_SIZE - 1)) && (r_col >= COL_W'(KERNEL_SIZE - 1)) &&
                 (!w_stride2 || (!r_row[0] && !r_col[0]));
  assign w_tag_last = (r_row == w_row_anchor) && (r_col == w_col_anchor);

  // Next-state, flush counter and done lookahead.
  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_cfg_start) w_state_nxt = ST_CFG;
        else             w_state_nxt = ST_IDLE;
      end
      ST_CFG: begin
        if (w_geom_ok) w_state_nxt = ST_RUN;
        else           w_state_nxt = ST_IDLE;
        w_flush_nxt = '0;
      end
      ST_RUN: begin
        if (w_hs && w_at_end) begin
          w_state_nxt = ST_FLUSH;
          w_flush_nxt = '0;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == FC_W'(WIN_LAT - 1)) begin
          w_state_nxt = ST_IDLE;
          w_flush_nxt = '0;
        end else begin
          w_flush_nxt = r_flush_cnt + FC_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_flush_nxt = '0;
      end
    endcase
    // Done is registered, so raise it one cycle ahead of the final flush count.
    w_done_nxt = ((r_state == ST_CFG) && !w_geom_ok) ||
                 ((w_state_nxt == ST_FLUSH) && (w_flush_nxt == FC_W'(WIN_LAT - 1)));
  end

  // Control state, geometry latch and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_img_w     <= '0;
      r_img_h     <= '0;
      r_buff_len  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_done      <= w_done_nxt;
      if (w_start_acc) begin
        r_img_w    <= i_cfg_img_w;
        r_img_h    <= i_cfg_img_h;
        r_buff_len <= ROW_BUFFER_DEPTH'(i_cfg_img_w - WW'(2));
        r_cfg_err  <= 1'b0;
      end else if ((r_state == ST_CFG) && !w_geom_ok) begin
        r_cfg_err  <= 1'b1;
      end else begin
        r_cfg_err  <= r_cfg_err;
      end
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == ST_CFG) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_hs) begin
      if (r_col == w_col_end) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end else begin
      r_col <= r_col;
      r_row <= r_row;
    end
  end

  assign o_s_ready       = (r_state == ST_RUN);
  assign o_pp_valid_in   = i_s_valid & o_s_ready;
  assign o_buff_len_rst  = (r_state == ST_CFG);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_buff_len_ctrl = r_buff_len;
  assign o_done          = r_done;
  assign o_cfg_err       = r_cfg_err;

  dw_win_tag_pipe #(
    .WIN_LAT (WIN_LAT)
  ) u_tag_pipe (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (o_pp_valid_in),
    .i_tag       (w_tag),
    .i_last      (w_tag_last),
    .o_win_valid (o_win_valid),
    .o_win_last  (o_win_last)
  );

endmodule
